// File: rtl/xor_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// xor_stage_pipe_if
// Handshake and data bundle for xor_stage_pipe.
//   in_valid / in_ready   : input-side valid/ready handshake
//   a, b, op              : operands and op select (00 XOR, 01 XNOR, 10 AND, 11 OR)
//   out_comb              : same-cycle combinational result, not valid-qualified
//   out_valid / out_ready : output-side valid/ready handshake
//   out_data              : registered result from the last stage
//   out_parity            : ^out_data, present only with XOR_STAGE_PIPE_PARITY_EN
// Modports: master = source/sink side (testbench or upstream/downstream),
//           slave  = the pipeline itself.
// ---------------------------------------------------------------------------
interface xor_stage_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [WIDTH-1:0] out_comb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef XOR_STAGE_PIPE_PARITY_EN
    logic             out_parity;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_comb, out_valid, out_data, out_parity
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_comb, out_valid, out_data, out_parity
    );
`else
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_comb, out_valid, out_data
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_comb, out_valid, out_data
    );
`endif
endinterface

// File: rtl/xor_stage_pipe.sv
// ---------------------------------------------------------------------------
// xor_stage_pipe
// Bitwise op (XOR/XNOR/AND/OR) on WIDTH-bit operands, presented both as a
// same-cycle combinational result and through a STAGES-deep valid/ready
// pipeline with backpressure.
//
// Parameters:
//   WIDTH  : operand/result width (1..64)
//   STAGES : register stages on the registered path (1..8)
// Ports:
//   clk    : clock, all state on posedge
//   rst    : synchronous active-high reset; clears every valid and data bit
//   bus    : xor_stage_pipe_if.slave (handshakes, operands, results)
// Optional build macro:
//   XOR_STAGE_PIPE_PARITY_EN : adds bus.out_parity = ^out_data, carried as an
//                              extra bit through every stage.
// ---------------------------------------------------------------------------

// One pipeline register stage. The stage is enabled by its ready bit, which
// the top computes as a single chain so the whole ready path lives in one
// combinational block.
module xor_stage_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,     // ready_k: stage may take its upstream
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    always_comb begin
        valid_d = en_i ? valid_i : valid_q;
        // A bubble clears valid but leaves the data register untouched.
        data_d  = (en_i && valid_i) ? data_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

module xor_stage_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    xor_stage_pipe_if.slave   bus
);
`ifdef XOR_STAGE_PIPE_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    // Stage word: result bits, plus the parity bit on top when enabled.
    localparam int DW = WIDTH + PW;

    logic [WIDTH-1:0]             res;
    logic [DW-1:0]                word_in;
    // Index 0 is the pipe input; index k+1 is the output of stage k.
    logic [STAGES:0]              vld;
    logic [STAGES:0][DW-1:0]      dat;
    // rdy[k] is ready for stage k; rdy[STAGES] is the downstream ready.
    logic [STAGES:0]              rdy;

    always_comb begin
        res = '0;
        unique case (bus.op)
            2'b00:   res = bus.a ^ bus.b;
            2'b01:   res = ~(bus.a ^ bus.b);
            2'b10:   res = bus.a & bus.b;
            default: res = bus.a | bus.b;
        endcase
    end

`ifdef XOR_STAGE_PIPE_PARITY_EN
    assign word_in = {^res, res};
`else
    assign word_in = res;
`endif

    assign bus.out_comb = res;
    assign vld[0]       = bus.in_valid;
    assign dat[0]       = word_in;

    // Ready chain evaluated from the output back to the input: a stage can
    // move when it is empty or the stage after it can move.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k+1] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        xor_stage_pipe_stage #(.DW(DW)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (rdy[k]),
            .valid_i (vld[k]),
            .data_i  (dat[k]),
            .valid_o (vld[k+1]),
            .data_o  (dat[k+1])
        );
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[STAGES];
    assign bus.out_data  = dat[STAGES][WIDTH-1:0];
`ifdef XOR_STAGE_PIPE_PARITY_EN
    assign bus.out_parity = dat[STAGES][WIDTH];
`endif
endmodule

// File: tb/tb_xor_stage_pipe.sv
module tb_xor_stage_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    xor_stage_pipe_if #(.WIDTH(8)) bus8 ();
    xor_stage_pipe_if #(.WIDTH(1)) bus1 ();

    xor_stage_pipe #(.WIDTH(8), .STAGES(2)) u8 (.clk(clk), .rst(rst), .bus(bus8));
    xor_stage_pipe #(.WIDTH(1), .STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bus8.in_valid = v;
        bus8.a        = a;
        bus8.b        = b;
        bus8.op       = op;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus8.out_valid); end
        checks++; if (bus8.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h exp 00", bus8.out_data); end
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus8.in_ready); end
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL rst_w1_out_valid got %b exp 0", bus1.out_valid); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        bus8.out_ready = 1'b1;
        drive8(1'b1, 8'h0F, 8'hFF, 2'b00);
        #1;
        checks++; if (bus8.out_comb !== 8'hF0) begin errors++; $display("FAIL single_comb got %h exp F0", bus8.out_comb); end
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", bus8.in_ready); end
        step();
        bus8.in_valid = 1'b0;
        #1;
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", bus8.out_valid); end
        step();
        checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus8.out_valid); end
        checks++; if (bus8.out_data !== 8'hF0) begin errors++; $display("FAIL single_data got %h exp F0", bus8.out_data); end
        step();
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL single_after got %b exp 0", bus8.out_valid); end
        checks++; if (bus8.out_data !== 8'hF0) begin errors++; $display("FAIL single_bubble_keep got %h exp F0", bus8.out_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h99; exp_d[1] = 8'h66; exp_d[2] = 8'h24; exp_d[3] = 8'hBD;
        bus8.out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            if (n < 4) drive8(1'b1, 8'hA5, 8'h3C, 2'(n));
            else       drive8(1'b0, 8'hA5, 8'h3C, 2'b00);
            #1;
            if (n < 4) begin
                checks++; if (bus8.out_comb !== exp_d[n]) begin errors++; $display("FAIL b2b_comb%0d got %h exp %h", n, bus8.out_comb, exp_d[n]); end
                checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d got %b exp 1", n, bus8.in_ready); end
            end
            step();
            if (n >= 1 && n <= 4) begin
                checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %b exp 1", n, bus8.out_valid); end
                checks++; if (bus8.out_data !== exp_d[n-1]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", n, bus8.out_data, exp_d[n-1]); end
            end else begin
                checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d got %b exp 0", n, bus8.out_valid); end
            end
        end
    endtask

    task automatic test_stall();
        bus8.out_ready = 1'b0;
        drive8(1'b1, 8'hA5, 8'h3C, 2'b00);
        #1;
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL stall_acc0 got %b exp 1", bus8.in_ready); end
        step();
        drive8(1'b1, 8'hA5, 8'h3C, 2'b01);
        #1;
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL stall_acc1 got %b exp 1", bus8.in_ready); end
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL stall_early got %b exp 0", bus8.out_valid); end
        step();
        drive8(1'b1, 8'hA5, 8'h3C, 2'b10);
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL stall_full%0d got %b exp 0", c, bus8.in_ready); end
            checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %b exp 1", c, bus8.out_valid); end
            checks++; if (bus8.out_data !== 8'h99) begin errors++; $display("FAIL stall_hold%0d got %h exp 99", c, bus8.out_data); end
            step();
        end
        bus8.out_ready = 1'b1;
        #1;
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", bus8.in_ready); end
        checks++; if (bus8.out_data !== 8'h99) begin errors++; $display("FAIL stall_drain0 got %h exp 99", bus8.out_data); end
        step();
        drive8(1'b1, 8'hA5, 8'h3C, 2'b11);
        #1;
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL stall_acc3 got %b exp 1", bus8.in_ready); end
        checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL stall_v1 got %b exp 1", bus8.out_valid); end
        checks++; if (bus8.out_data !== 8'h66) begin errors++; $display("FAIL stall_drain1 got %h exp 66", bus8.out_data); end
        step();
        bus8.in_valid = 1'b0;
        #1;
        checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL stall_v2 got %b exp 1", bus8.out_valid); end
        checks++; if (bus8.out_data !== 8'h24) begin errors++; $display("FAIL stall_drain2 got %h exp 24", bus8.out_data); end
        step();
        checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL stall_v3 got %b exp 1", bus8.out_valid); end
        checks++; if (bus8.out_data !== 8'hBD) begin errors++; $display("FAIL stall_drain3 got %h exp BD", bus8.out_data); end
        step();
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b exp 0", bus8.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus8.out_ready = 1'b0;
        drive8(1'b1, 8'hA5, 8'h3C, 2'b00);
        step();
        drive8(1'b1, 8'hA5, 8'h3C, 2'b11);
        step();
        bus8.in_valid = 1'b0;
        #1;
        checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full got %b exp 0", bus8.in_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", bus8.out_valid); end
        checks++; if (bus8.out_data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h exp 00", bus8.out_data); end
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", bus8.in_ready); end
        bus8.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_ghost%0d got %b exp 0", c, bus8.out_valid); end
        end
    endtask

    task automatic test_width1();
        bus1.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        bus1.op        = 2'b00;
        bus1.a = 1'b0; bus1.b = 1'b1;
        #1;
        checks++; if (bus1.out_comb !== 1'b1) begin errors++; $display("FAIL w1_comb0 got %b exp 1", bus1.out_comb); end
        step();
        checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL w1_valid0 got %b exp 1", bus1.out_valid); end
        checks++; if (bus1.out_data !== 1'b1) begin errors++; $display("FAIL w1_data0 got %b exp 1", bus1.out_data); end
        bus1.a = 1'b1; bus1.b = 1'b0;
        #1;
        checks++; if (bus1.out_comb !== 1'b1) begin errors++; $display("FAIL w1_comb1 got %b exp 1", bus1.out_comb); end
        step();
        bus1.in_valid = 1'b0;
        bus1.a = 1'b1; bus1.b = 1'b1;
        #1;
        checks++; if (bus1.out_comb !== 1'b0) begin errors++; $display("FAIL w1_comb2 got %b exp 0", bus1.out_comb); end
        checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL w1_valid1 got %b exp 1", bus1.out_valid); end
        checks++; if (bus1.out_data !== 1'b1) begin errors++; $display("FAIL w1_data1 got %b exp 1", bus1.out_data); end
        step();
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL w1_idle got %b exp 0", bus1.out_valid); end
    endtask

    task automatic test_parity();
        bus8.out_ready = 1'b1;
        drive8(1'b1, 8'h07, 8'h00, 2'b00);
        step();
        drive8(1'b1, 8'h03, 8'h00, 2'b00);
        step();
        bus8.in_valid = 1'b0;
        #1;
        checks++; if (bus8.out_data !== 8'h07) begin errors++; $display("FAIL par_data0 got %h exp 07", bus8.out_data); end
`ifdef XOR_STAGE_PIPE_PARITY_EN
        checks++; if (bus8.out_parity !== 1'b1) begin errors++; $display("FAIL par_bit0 got %b exp 1", bus8.out_parity); end
`endif
        step();
        checks++; if (bus8.out_data !== 8'h03) begin errors++; $display("FAIL par_data1 got %h exp 03", bus8.out_data); end
`ifdef XOR_STAGE_PIPE_PARITY_EN
        checks++; if (bus8.out_parity !== 1'b0) begin errors++; $display("FAIL par_bit1 got %b exp 0", bus8.out_parity); end
`endif
        step();
    endtask

    initial begin
        drive8(1'b0, 8'h00, 8'h00, 2'b00);
        bus8.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.a         = 1'b0;
        bus1.b         = 1'b0;
        bus1.op        = 2'b00;
        bus1.out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_width1();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
